// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target responder.
// Contents: FSM state encoding, byte and bit-counter widths, bus-level
// constants for ACK/NACK and the read/write bit.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_PTR      = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8
    } state_t;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C line (SCL or SDA) into the system clock domain.
// The line passes through a synchroniser preset to 1. When I2C_GLITCH_FILTER_EN
// is defined, a 3-sample majority filter follows, which rejects pulses shorter
// than 2 clks and adds 2 clks of latency.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   line_in raw line from the pad
//   level   conditioned line level
//   rise_c  one-clk pulse on a 0->1 transition of level (combinational)
//   fall_c  one-clk pulse on a 1->0 transition of level (combinational)
module i2c_line_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   cond;
    logic                   prev;

    // Synchroniser; the idle bus level is 1
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt;

    // Majority of the current synchronised sample and the two before it
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
            filt <= 1'b1;
        end else begin
            hist <= {hist[0], sync[SYNC_STAGES-1]};
            filt <= (sync[SYNC_STAGES-1] & hist[0]) |
                    (sync[SYNC_STAGES-1] & hist[1]) |
                    (hist[0] & hist[1]);
        end
    end

    assign cond = filt;
`else
    assign cond = sync[SYNC_STAGES-1];
`endif

    // Previous level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= cond;
        end
    end

    assign level  = cond;
    assign rise_c = cond & ~prev;
    assign fall_c = ~cond & prev;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with an 8-bit register pointer, oversampled on sys_clk_12m.
// Never drives SCL; SDA is open-drain through sda_oe.
// Optional feature: define I2C_GLITCH_FILTER_EN to add a majority glitch
// filter on both lines (see i2c_line_cond).
// Ports:
//   sys_clk_12m  system clock
//   rst          synchronous active-high reset
//   scl, sda_in  bus lines as seen at the pads
//   sda_oe       1 = pull SDA low
//   reg_addr     register pointer
//   reg_wdata    write data, valid with reg_we
//   reg_we       one-clk write strobe
//   reg_re       one-clk read request; reg_rdata valid one clk later
//   reg_rdata    read data from the register bank
//   busy         high from address match until STOP or return to idle
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk_12m,
    input  logic              rst,
    input  logic              scl,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [BYTE_W-1:0] reg_addr,
    output logic [BYTE_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [BYTE_W-1:0] reg_rdata,
    output logic              busy
);

    state_t             state, state_nxt;
    logic               scl_lvl, scl_rise, scl_fall;
    logic               sda_lvl, sda_rise, sda_fall;
    logic               start_c, stop_c;
    logic [BYTE_W-1:0]  sh, sh_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               rw, rw_nxt;
    logic               mack, mack_nxt;
    logic               re_d;
    logic               sda_oe_nxt, we_nxt, re_nxt, busy_nxt;
    logic [BYTE_W-1:0]  addr_nxt, wdata_nxt;
    logic [BYTE_W-1:0]  rx_byte;
    logic               last_bit;
    logic               addr_match;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk     (sys_clk_12m),
        .rst     (rst),
        .line_in (scl),
        .level   (scl_lvl),
        .rise_c  (scl_rise),
        .fall_c  (scl_fall)
    );

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk     (sys_clk_12m),
        .rst     (rst),
        .line_in (sda_in),
        .level   (sda_lvl),
        .rise_c  (sda_rise),
        .fall_c  (sda_fall)
    );

    assign start_c    = sda_fall & scl_lvl;
    assign stop_c     = sda_rise & scl_lvl;
    assign rx_byte    = {sh[BYTE_W-2:0], sda_lvl};
    assign last_bit   = (cnt == CNT_W'(7));
    assign addr_match = (rx_byte[7:1] == DEV_ADDR);

    // State register
    always_ff @(posedge sys_clk_12m) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; bus conditions win over bit handling.
    // In the ACK states sda_oe itself marks whether the ACK pulse has begun.
    always_comb begin
        state_nxt = state;
        if (start_c) begin
            state_nxt = S_ADDR;
        end else if (stop_c) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     state_nxt = S_IDLE;
                S_ADDR:     if (scl_rise && last_bit) state_nxt = addr_match ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK: if (scl_fall && sda_oe) state_nxt = (rw == I2C_RW_READ) ? S_RD_DATA : S_PTR;
                S_PTR:      if (scl_rise && last_bit) state_nxt = S_PTR_ACK;
                S_PTR_ACK:  if (scl_fall && sda_oe) state_nxt = S_WR_DATA;
                S_WR_DATA:  if (scl_rise && last_bit) state_nxt = S_WR_ACK;
                S_WR_ACK:   if (scl_fall && sda_oe) state_nxt = S_WR_DATA;
                S_RD_DATA:  if (scl_fall && last_bit) state_nxt = S_RD_ACK;
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) state_nxt = S_IDLE;
                    end else if (scl_fall && mack) begin
                        state_nxt = S_RD_DATA;
                    end
                end
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        sda_oe_nxt = sda_oe;
        we_nxt     = 1'b0;
        re_nxt     = 1'b0;
        addr_nxt   = reg_addr;
        wdata_nxt  = reg_wdata;
        busy_nxt   = busy;
        sh_nxt     = sh;
        cnt_nxt    = cnt;
        rw_nxt     = rw;
        mack_nxt   = mack;

        // Read data arrives one clk after the request
        if (re_d) sh_nxt = reg_rdata;

        if (start_c) begin
            sda_oe_nxt = 1'b0;
            cnt_nxt    = '0;
        end else if (stop_c) begin
            sda_oe_nxt = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_PTR, S_WR_DATA: begin
                    if (scl_rise) begin
                        sh_nxt  = rx_byte;
                        cnt_nxt = cnt + CNT_W'(1);
                        if (last_bit) begin
                            if (state == S_ADDR && addr_match) begin
                                busy_nxt = 1'b1;
                                rw_nxt   = rx_byte[0];
                            end
                            if (state == S_PTR) addr_nxt = rx_byte;
                            if (state == S_WR_DATA) begin
                                wdata_nxt = rx_byte;
                                we_nxt    = 1'b1;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                            if (state == S_ADDR_ACK && rw == I2C_RW_READ) re_nxt = 1'b1;
                        end else begin
                            // ACK ends; a read starts driving its first bit right here
                            sda_oe_nxt = (state == S_ADDR_ACK && rw == I2C_RW_READ) ? ~sh[7] : 1'b0;
                            cnt_nxt    = '0;
                            mack_nxt   = 1'b0;
                            if (state == S_WR_ACK) addr_nxt = reg_addr + BYTE_W'(1);
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (last_bit) begin
                            sda_oe_nxt = 1'b0;
                            cnt_nxt    = '0;
                            mack_nxt   = 1'b0;
                        end else begin
                            sda_oe_nxt = ~sh[6];
                            sh_nxt     = {sh[BYTE_W-2:0], 1'b0};
                            cnt_nxt    = cnt + CNT_W'(1);
                        end
                    end
                end
                S_RD_ACK: begin
                    // Fetch the next byte during the ACK high phase so bit 7 is ready at the fall
                    if (scl_rise) begin
                        if (sda_lvl == I2C_ACK) begin
                            mack_nxt = 1'b1;
                            addr_nxt = reg_addr + BYTE_W'(1);
                            re_nxt   = 1'b1;
                        end
                    end else if (scl_fall && mack) begin
                        sda_oe_nxt = ~sh[7];
                        cnt_nxt    = '0;
                        mack_nxt   = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (state_nxt == S_IDLE) begin
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge sys_clk_12m) begin
        if (rst) begin
            sda_oe    <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            busy      <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            rw        <= 1'b0;
            mack      <= 1'b0;
            re_d      <= 1'b0;
        end else begin
            sda_oe    <= sda_oe_nxt;
            reg_we    <= we_nxt;
            reg_re    <= re_nxt;
            reg_addr  <= addr_nxt;
            reg_wdata <= wdata_nxt;
            busy      <= busy_nxt;
            sh        <= sh_nxt;
            cnt       <= cnt_nxt;
            rw        <= rw_nxt;
            mack      <= mack_nxt;
            re_d      <= reg_re;
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bus master model drives SCL/SDA, a small
// register bank answers reads, and a monitor matches write/read strobes
// against queues of expected transactions.
module tb_i2c_slave_responder;

    localparam int HALF = 12;
    localparam int QTR  = 6;

    logic       clk;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    logic [7:0] mem [256];

    logic [15:0] we_q [$];
    logic [7:0]  re_q [$];
    logic [7:0]  rd_q [$];

    int n_checks = 0;
    int n_errors = 0;

    logic        we_prev = 1'b0;
    logic        re_prev = 1'b0;
    logic [15:0] we_exp;
    logic [7:0]  re_exp;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder dut (
        .sys_clk_12m (clk),
        .rst         (rst),
        .scl         (scl_m),
        .sda_in      (sda_bus),
        .sda_oe      (sda_oe),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_rdata   (reg_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #41 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Register bank model: read data valid one clk after reg_re
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_we) mem[reg_addr] <= reg_wdata;
    end

    // Strobe monitor
    always @(negedge clk) begin
        if (reg_we) begin
            check("we_re_excl", 32'(reg_re), 32'd0);
            check("we_width", 32'(we_prev), 32'd0);
            if (we_q.size() == 0) begin
                check("we_unexpected", 32'(reg_we), 32'd0);
            end else begin
                we_exp = we_q.pop_front();
                check("we_addr", 32'(reg_addr), 32'(we_exp[15:8]));
                check("we_data", 32'(reg_wdata), 32'(we_exp[7:0]));
            end
        end
        if (reg_re) begin
            check("re_width", 32'(re_prev), 32'd0);
            if (re_q.size() == 0) begin
                check("re_unexpected", 32'(reg_re), 32'd0);
            end else begin
                re_exp = re_q.pop_front();
                check("re_addr", 32'(reg_addr), 32'(re_exp));
            end
        end
        we_prev = reg_we;
        re_prev = reg_re;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        clks(QTR); sda_m = 1'b1;
        clks(QTR); scl_m = 1'b1;
        clks(QTR); sda_m = 1'b0;
        clks(QTR); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        clks(QTR); sda_m = 1'b0;
        clks(QTR); scl_m = 1'b1;
        clks(QTR); sda_m = 1'b1;
        clks(HALF);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        clks(QTR); sda_m = b;
        clks(QTR); scl_m = 1'b1;
        if (glitch) begin
            clks(4); scl_m = 1'b0;
            clks(1); scl_m = 1'b1;
            clks(HALF - 5);
        end else begin
            clks(HALF);
        end
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input string tag, input logic [7:0] b, input logic exp_ack, input int glitch_bit);
        logic ack;
        for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_bit);
        clks(QTR); sda_m = 1'b1;
        clks(QTR); scl_m = 1'b1;
        clks(QTR); ack = sda_bus;
        clks(QTR); scl_m = 1'b0;
        check(tag, 32'(ack), 32'(exp_ack));
    endtask

    task automatic read_byte(input string tag, input logic master_ack);
        logic [7:0] v;
        logic [7:0] e;
        v = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clks(HALF); scl_m = 1'b1;
            clks(QTR);  v = {v[6:0], sda_bus};
            clks(QTR);  scl_m = 1'b0;
        end
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hxx;
        check(tag, 32'(v), 32'(e));
        clks(QTR); sda_m = master_ack ? 1'b0 : 1'b1;
        clks(QTR); scl_m = 1'b1;
        clks(HALF); scl_m = 1'b0;
        clks(2); sda_m = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        clks(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_re", 32'(reg_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        rst = 1'b0;
        clks(5);

        // Two-byte write
        we_q.push_back({8'h10, 8'hA5});
        we_q.push_back({8'h11, 8'h5A});
        i2c_start();
        write_byte("t1_addr_ack", 8'h90, 1'b0, -1);
        check("t1_busy_on", 32'(busy), 32'd1);
        write_byte("t1_ptr_ack", 8'h10, 1'b0, -1);
        write_byte("t1_d0_ack", 8'hA5, 1'b0, -1);
        write_byte("t1_d1_ack", 8'h5A, 1'b0, -1);
        i2c_stop();
        check("t1_busy_off", 32'(busy), 32'd0);

        // Pointer write, repeated START, two-byte read
        re_q.push_back(8'h20);
        re_q.push_back(8'h21);
        rd_q.push_back(8'h3C);
        rd_q.push_back(8'hC3);
        i2c_start();
        write_byte("t2_addr_ack", 8'h90, 1'b0, -1);
        write_byte("t2_ptr_ack", 8'h20, 1'b0, -1);
        i2c_start();
        write_byte("t2_raddr_ack", 8'h91, 1'b0, -1);
        read_byte("t2_rd0", 1'b1);
        read_byte("t2_rd1", 1'b0);
        i2c_stop();
        check("t2_busy_off", 32'(busy), 32'd0);
        check("t2_ptr_kept", 32'(reg_addr), 32'h21);
        check("t2_sda_rel", 32'(sda_oe), 32'd0);

        // Foreign address is ignored
        i2c_start();
        write_byte("t3_nack", 8'hA0, 1'b1, -1);
        check("t3_busy", 32'(busy), 32'd0);
        i2c_stop();

        // Pointer wrap
        we_q.push_back({8'hFF, 8'h11});
        we_q.push_back({8'h00, 8'h22});
        i2c_start();
        write_byte("t4_addr_ack", 8'h90, 1'b0, -1);
        write_byte("t4_ptr_ack", 8'hFF, 1'b0, -1);
        write_byte("t4_d0_ack", 8'h11, 1'b0, -1);
        write_byte("t4_d1_ack", 8'h22, 1'b0, -1);
        i2c_stop();
        check("t4_ptr_wrap", 32'(reg_addr), 32'h01);

        // Truncated write byte, then reset in the middle of a read
        i2c_start();
        write_byte("t5_addr_ack", 8'h90, 1'b0, -1);
        write_byte("t5_ptr_ack", 8'h30, 1'b0, -1);
        for (int i = 0; i < 4; i++) write_bit(1'b1, 1'b0);
        i2c_stop();
        check("t5_busy_off", 32'(busy), 32'd0);
        re_q.push_back(8'h30);
        i2c_start();
        write_byte("t5_raddr_ack", 8'h91, 1'b0, -1);
        for (int i = 0; i < 2; i++) begin
            clks(HALF); scl_m = 1'b1;
            clks(HALF); scl_m = 1'b0;
        end
        clks(QTR);
        check("t5_oe_driving", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        check("t5_rst_oe", 32'(sda_oe), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_addr", 32'(reg_addr), 32'd0);
        i2c_stop();

        // One-clk SCL glitch during the MSB of a data byte
`ifdef I2C_GLITCH_FILTER_EN
        we_q.push_back({8'h40, 8'hA5});
`else
        we_q.push_back({8'h40, 8'hD2});
`endif
        i2c_start();
        write_byte("t6_addr_ack", 8'h90, 1'b0, -1);
        write_byte("t6_ptr_ack", 8'h40, 1'b0, -1);
`ifdef I2C_GLITCH_FILTER_EN
        write_byte("t6_data_ack", 8'hA5, 1'b0, 7);
`else
        write_byte("t6_data_ack", 8'hA5, 1'b1, 7);
`endif
        i2c_stop();

        clks(20);
        check("we_q_drained", 32'(we_q.size()), 32'd0);
        check("re_q_drained", 32'(re_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
